hazard_forward_unit: RTL and testbench

// - Hazard and forwarding controller for the 5-stage RISC-V pipeline; produces the 2-bit

---
 rtl/hazard_pkg.sv | 19 +
 rtl/hfu_match.sv | 15 +
 rtl/hazard_forward_unit.sv | 104 ++++++++++
 tb/tb_hazard_forward_unit.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: forward-select encodings, register-zero index and stage-metadata widths
package hazard_pkg;
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam int REG_ZERO = 0;
    // ex: valid, rs1, rs2, rs1_used, rs2_used, rd, reg_write, mem_read
    function automatic int ex_meta_w(int aw);
        return 3 * aw + 5;
    endfunction
    // mem: valid, rd, reg_write, mem_read
    function automatic int mem_meta_w(int aw);
        return aw + 3;
    endfunction
    // wb: valid, rd, reg_write
    function automatic int wb_meta_w(int aw);
        return aw + 2;
    endfunction
endpackage

// File: rtl/hfu_match.sv
// hfu_match: a producer stage hits a consumer source register (x0 never hits)
module hfu_match
    import hazard_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic          valid,
    input  logic          reg_write,
    input  logic [AW-1:0] rd,
    input  logic [AW-1:0] rs,
    input  logic          used,
    output logic          hit
);
    assign hit = valid & reg_write & used & (rd != AW'(REG_ZERO)) & (rd == rs);
endmodule

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: shadow EX/MEM/WB metadata pipeline driving operand forwarding,
// load-use stall, branch flush, dmem freeze and ID-stage WB bypass flags.
module hazard_forward_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W       = 5,
    parameter bit RF_WRITE_THROUGH = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  ex_branch_taken,
    input  logic                  dmem_stall,
    output logic [1:0]            forward_a,
    output logic [1:0]            forward_b,
    output logic                  id_wb_bypass_a,
    output logic                  id_wb_bypass_b,
    output logic                  stall_pc,
    output logic                  stall_if_id,
    output logic                  stall_id_ex,
    output logic                  flush_if_id,
    output logic                  flush_id_ex
);
    localparam int AW = REG_ADDR_W;

    logic [ex_meta_w(AW)-1:0]  ex_q;
    logic [mem_meta_w(AW)-1:0] mem_q;
    logic [wb_meta_w(AW)-1:0]  wb_q;
    logic                      warm;

    logic          ex_valid, ex_rs1_used, ex_rs2_used, ex_reg_write, ex_mem_read;
    logic [AW-1:0] ex_rs1, ex_rs2, ex_rd;
    logic          mem_valid, mem_reg_write, mem_mem_read;
    logic [AW-1:0] mem_rd;
    logic          wb_valid, wb_reg_write;
    logic [AW-1:0] wb_rd;

    assign {ex_valid, ex_rs1, ex_rs2, ex_rs1_used, ex_rs2_used, ex_rd, ex_reg_write, ex_mem_read} = ex_q;
    assign {mem_valid, mem_rd, mem_reg_write, mem_mem_read} = mem_q;
    assign {wb_valid, wb_rd, wb_reg_write} = wb_q;

    logic mem_a, mem_b, wb_a, wb_b, lu_a, lu_b, byp_a, byp_b;

    hfu_match #(.AW(AW)) u_mem_a (.valid(mem_valid & ex_valid), .reg_write(mem_reg_write & ~mem_mem_read),
                                  .rd(mem_rd), .rs(ex_rs1), .used(ex_rs1_used), .hit(mem_a));
    hfu_match #(.AW(AW)) u_mem_b (.valid(mem_valid & ex_valid), .reg_write(mem_reg_write & ~mem_mem_read),
                                  .rd(mem_rd), .rs(ex_rs2), .used(ex_rs2_used), .hit(mem_b));
    hfu_match #(.AW(AW)) u_wb_a  (.valid(wb_valid & ex_valid), .reg_write(wb_reg_write),
                                  .rd(wb_rd), .rs(ex_rs1), .used(ex_rs1_used), .hit(wb_a));
    hfu_match #(.AW(AW)) u_wb_b  (.valid(wb_valid & ex_valid), .reg_write(wb_reg_write),
                                  .rd(wb_rd), .rs(ex_rs2), .used(ex_rs2_used), .hit(wb_b));
    // a load in EX is the "producer" for the load-use check against ID sources
    hfu_match #(.AW(AW)) u_lu_a  (.valid(ex_valid & id_valid), .reg_write(ex_mem_read),
                                  .rd(ex_rd), .rs(id_rs1), .used(id_rs1_used), .hit(lu_a));
    hfu_match #(.AW(AW)) u_lu_b  (.valid(ex_valid & id_valid), .reg_write(ex_mem_read),
                                  .rd(ex_rd), .rs(id_rs2), .used(id_rs2_used), .hit(lu_b));
    hfu_match #(.AW(AW)) u_byp_a (.valid(wb_valid), .reg_write(wb_reg_write),
                                  .rd(wb_rd), .rs(id_rs1), .used(id_rs1_used), .hit(byp_a));
    hfu_match #(.AW(AW)) u_byp_b (.valid(wb_valid), .reg_write(wb_reg_write),
                                  .rd(wb_rd), .rs(id_rs2), .used(id_rs2_used), .hit(byp_b));

    logic active, freeze, redirect, load_use;

    // outputs stay quiet while in reset and for the first cycle out of it
    always_comb begin
        active         = ~rst & warm;
        freeze         = active & dmem_stall;
        redirect       = active & ~dmem_stall & ex_branch_taken;
        load_use       = active & ~dmem_stall & ~ex_branch_taken & (lu_a | lu_b);
        stall_pc       = freeze | load_use;
        stall_if_id    = freeze | load_use;
        stall_id_ex    = freeze;
        flush_if_id    = redirect;
        flush_id_ex    = redirect | load_use;
        forward_a      = !active ? FWD_RF : mem_a ? FWD_MEM : wb_a ? FWD_WB : FWD_RF;
        forward_b      = !active ? FWD_RF : mem_b ? FWD_MEM : wb_b ? FWD_WB : FWD_RF;
        id_wb_bypass_a = !RF_WRITE_THROUGH & active & byp_a;
        id_wb_bypass_b = !RF_WRITE_THROUGH & active & byp_b;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            warm  <= 1'b0;
        end else begin
            warm <= 1'b1;
            if (!stall_id_ex) begin
                wb_q  <= {mem_valid, mem_rd, mem_reg_write};
                mem_q <= {ex_valid, ex_rd, ex_reg_write, ex_mem_read};
                ex_q  <= {id_valid & ~flush_id_ex, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
                          id_rd, id_reg_write, id_mem_read};
            end
        end
    end
endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit: directed scenarios plus randomized traffic against a stage-list reference model
module tb_hazard_forward_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, id_valid, id_rs1_used, id_rs2_used, id_reg_write, id_mem_read;
    logic       ex_branch_taken, dmem_stall;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic [1:0] forward_a, forward_b;
    logic       id_wb_bypass_a, id_wb_bypass_b, stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex;

    int checks = 0;
    int fails = 0;

    hazard_forward_unit dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .ex_branch_taken(ex_branch_taken),
        .dmem_stall(dmem_stall), .forward_a(forward_a), .forward_b(forward_b),
        .id_wb_bypass_a(id_wb_bypass_a), .id_wb_bypass_b(id_wb_bypass_b), .stall_pc(stall_pc),
        .stall_if_id(stall_if_id), .stall_id_ex(stall_id_ex), .flush_if_id(flush_if_id),
        .flush_id_ex(flush_id_ex)
    );

    // in-flight instruction list: index 0 = EX, 1 = MEM, 2 = WB
    typedef struct {
        logic       v;
        logic [4:0] rs1, rs2;
        logic       u1, u2;
        logic [4:0] rd;
        logic       w, ld;
    } stage_t;
    stage_t pipe [3];
    logic   warm = 1'b0;

    function automatic logic [10:0] outs();
        return {forward_a, forward_b, id_wb_bypass_a, id_wb_bypass_b, stall_pc, stall_if_id,
                stall_id_ex, flush_if_id, flush_id_ex};
    endfunction

    // youngest older producer wins; a load still in MEM has no data yet
    function automatic logic [1:0] fwd(logic [4:0] rs, logic used);
        if (!pipe[0].v || !used) return 2'b00;
        for (int s = 1; s <= 2; s++)
            if (pipe[s].v && pipe[s].w && pipe[s].rd != 0 && !(s == 1 && pipe[s].ld) && pipe[s].rd == rs)
                return (s == 1) ? 2'b10 : 2'b01;
        return 2'b00;
    endfunction

    function automatic logic wbp(logic [4:0] rs, logic used);
        return pipe[2].v && pipe[2].w && pipe[2].rd != 0 && used && pipe[2].rd == rs;
    endfunction

    function automatic logic [10:0] model_out();
        logic [10:0] e;
        logic lu;
        e = '0;
        if (rst || !warm) return e;
        e[10:9] = fwd(pipe[0].rs1, pipe[0].u1);
        e[8:7]  = fwd(pipe[0].rs2, pipe[0].u2);
        e[6]    = wbp(id_rs1, id_rs1_used);
        e[5]    = wbp(id_rs2, id_rs2_used);
        lu = pipe[0].v && pipe[0].ld && pipe[0].rd != 0 && id_valid &&
             ((id_rs1_used && id_rs1 == pipe[0].rd) || (id_rs2_used && id_rs2 == pipe[0].rd));
        if (dmem_stall) e[4:2] = 3'b111;
        else if (ex_branch_taken) e[1:0] = 2'b11;
        else if (lu) begin
            e[4] = 1'b1;
            e[3] = 1'b1;
            e[0] = 1'b1;
        end
        return e;
    endfunction

    task automatic tick();
        logic [10:0] e;
        e = model_out();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 3; i++) pipe[i].v = 1'b0;
            warm = 1'b0;
        end else begin
            warm = 1'b1;
            if (!e[2]) begin
                pipe[2] = pipe[1];
                pipe[1] = pipe[0];
                pipe[0] = '{id_valid & !e[0], id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_reg_write, id_mem_read};
            end
        end
        #1;
    endtask

    task automatic set_id(logic v, logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                          logic [4:0] rd, logic w, logic ld);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rs1_used = u1; id_rs2_used = u2;
        id_rd = rd; id_reg_write = w; id_mem_read = ld;
    endtask

    task automatic drain();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        ex_branch_taken = 0; dmem_stall = 0; rst = 0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst = 1; set_id(1, 1, 1, 1, 1, 1, 1, 1); ex_branch_taken = 1; dmem_stall = 1;
        tick(); tick(); #1;
        checks++; if (outs() !== 11'b0) begin fails++; $display("FAIL reset_held: got %b want 0", outs()); end
        rst = 0; #1;
        checks++; if (outs() !== 11'b0) begin fails++; $display("FAIL reset_first_cycle: got %b want 0", outs()); end
        tick(); ex_branch_taken = 0; dmem_stall = 0; #1;
        checks++; if (outs() !== model_out()) begin fails++; $display("FAIL reset_after: got %b want %b", outs(), model_out()); end
    endtask

    task automatic test_fwd_mem();
        drain();
        set_id(1, 1, 2, 1, 1, 5, 1, 0); tick();
        set_id(1, 5, 6, 1, 1, 8, 1, 0); tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0); #1;
        checks++; if (forward_a !== 2'b10) begin fails++; $display("FAIL fwd_mem_a: got %b want 10", forward_a); end
        checks++; if (forward_b !== 2'b00) begin fails++; $display("FAIL fwd_mem_b: got %b want 00", forward_b); end
    endtask

    task automatic test_mem_over_wb();
        drain();
        set_id(1, 1, 0, 1, 0, 5, 1, 0); tick();
        set_id(1, 5, 0, 1, 0, 5, 1, 0); tick();
        set_id(1, 1, 5, 1, 1, 9, 1, 0); tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0); #1;
        checks++; if (forward_b !== 2'b10) begin fails++; $display("FAIL mem_over_wb_b: got %b want 10", forward_b); end
        checks++; if (forward_a !== 2'b00) begin fails++; $display("FAIL mem_over_wb_a: got %b want 00", forward_a); end
    endtask

    task automatic test_load_use();
        drain();
        set_id(1, 2, 0, 1, 0, 7, 1, 1); tick();
        set_id(1, 7, 3, 1, 1, 10, 1, 0); #1;
        checks++; if ({stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex} !== 5'b11001) begin
            fails++; $display("FAIL load_use_stall: got %b want 11001", {stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex}); end
        tick(); #1;
        checks++; if ({stall_pc, stall_if_id, flush_id_ex} !== 3'b000) begin
            fails++; $display("FAIL load_use_one_cycle: got %b want 000", {stall_pc, stall_if_id, flush_id_ex}); end
        tick();
        set_id(1, 4, 7, 1, 1, 11, 1, 0); #1;
        checks++; if (forward_a !== 2'b01) begin fails++; $display("FAIL load_use_fwd_wb: got %b want 01", forward_a); end
        checks++; if ({id_wb_bypass_a, id_wb_bypass_b} !== 2'b01) begin
            fails++; $display("FAIL id_bypass: got %b want 01", {id_wb_bypass_a, id_wb_bypass_b}); end
    endtask

    task automatic test_x0();
        drain();
        set_id(1, 1, 0, 1, 0, 0, 1, 0); tick();
        set_id(1, 0, 0, 1, 1, 3, 1, 0); tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0); #1;
        checks++; if (forward_a !== 2'b00) begin fails++; $display("FAIL x0_no_fwd: got %b want 00", forward_a); end
        drain();
        set_id(1, 0, 0, 0, 0, 0, 1, 1); tick();
        set_id(1, 0, 0, 1, 1, 4, 1, 0); #1;
        checks++; if ({stall_pc, flush_id_ex} !== 2'b00) begin
            fails++; $display("FAIL x0_no_stall: got %b want 00", {stall_pc, flush_id_ex}); end
    endtask

    task automatic test_branch_dmem();
        drain();
        set_id(1, 1, 0, 1, 0, 9, 1, 1); tick();
        set_id(1, 0, 9, 0, 1, 12, 1, 0); ex_branch_taken = 1; #1;
        checks++; if ({stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex} !== 5'b00011) begin
            fails++; $display("FAIL branch_over_lu: got %b want 00011", {stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex}); end
        dmem_stall = 1; #1;
        checks++; if ({stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex} !== 5'b11100) begin
            fails++; $display("FAIL dmem_priority: got %b want 11100", {stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex}); end
        tick();
        dmem_stall = 0; ex_branch_taken = 0; #1;
        checks++; if (stall_pc !== 1'b1) begin fails++; $display("FAIL dmem_hold_state: stall_pc got %b want 1", stall_pc); end
        ex_branch_taken = 1; #1;
        checks++; if ({flush_if_id, flush_id_ex} !== 2'b11) begin
            fails++; $display("FAIL branch_reassert: got %b want 11", {flush_if_id, flush_id_ex}); end
        ex_branch_taken = 0;
        tick();
    endtask

    task automatic test_reset_mid_stall();
        drain();
        set_id(1, 2, 0, 1, 0, 7, 1, 1); tick();
        set_id(1, 7, 7, 1, 1, 13, 1, 0); #1;
        checks++; if (stall_pc !== 1'b1) begin fails++; $display("FAIL pre_reset_stall: got %b want 1", stall_pc); end
        rst = 1; tick(); rst = 0; ex_branch_taken = 1; #1;
        checks++; if (outs() !== 11'b0) begin fails++; $display("FAIL reset_mid_stall: got %b want 0", outs()); end
        ex_branch_taken = 0;
        tick();
    endtask

    task automatic test_random();
        logic [10:0] e;
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 49) == 0);
            set_id(1'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                   5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
            ex_branch_taken = ($urandom_range(0, 9) == 0);
            dmem_stall = ($urandom_range(0, 9) == 0);
            #1;
            e = model_out();
            checks++; if (outs() !== e) begin fails++; $display("FAIL random[%0d]: got %b want %b", n, outs(), e); end
            tick();
        end
        rst = 0;
    endtask

    initial begin
        rst = 1; ex_branch_taken = 0; dmem_stall = 0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 0, 0, 0, 0, 0};
        test_reset();
        test_fwd_mem();
        test_mem_over_wb();
        test_load_use();
        test_x0();
        test_branch_dmem();
        test_reset_mid_stall();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
